zorro_slot_arbiter: RTL and testbench
=====================================

ZORRO_SLOT_ARBITER -- requirements
Module: zorro_slot_arbiter

Interface
REQ-001 Parameter NSLOTS, default 4, number of expansion slots arbitrated (2..8).
REQ-002 CLK  input  1  bus clock; all state changes on rising edge.
REQ-003 RESET_n  input  1  synchronous, active-low reset, sampled on rising edge of CLK.
REQ-004 EBR_n  input  NSLOTS  per-slot registration request; asynchronous; a falling edge toggles that slot's registration.
REQ-005 FCS  input  1  high = bus cycle in progress.
REQ-006 DTACK  input  1  high = current cycle acknowledged.
REQ-007 RST  input  1  high = bus reset; clears all registrations.
REQ-008 EBG_n  output  NSLOTS  per-slot grant, active low, at most one asserted.
REQ-009 HOSTGNT  output  1  high = host CPU owns bus (no slot granted).
REQ-010 REGED  output  NSLOTS  registration status per slot.
REQ-011 OWNER  output  3  index of granted slot; 0 when HOSTGNT=1.

Function
REQ-012 Each EBR_n bit SHALL pass a 2-flop synchronizer, then a falling-edge detector; total pin-to-REGED-toggle latency = 3 CLK.
REQ-013 A detected edge SHALL toggle REGED[i]; simultaneous edges on several slots SHALL all toggle in the same cycle.
REQ-014 State machine SHALL have states HOST, WAIT, GRANT, RELEASE; reset state HOST.
REQ-015 HOST: HOSTGNT=1, all EBG_n=1; any REGED bit set -> WAIT.
REQ-016 WAIT: HOSTGNT=0 and EBG_n all 1; winner selected per REQ-021; when FCS=0 for one sampled cycle -> GRANT with EBG_n[winner]=0 and OWNER=winner on the next edge (1 CLK latency); if REGED becomes all 0 -> HOST.
REQ-017 A cycle with FCS=1 and DTACK=0 in WAIT SHALL hold WAIT; grant never issued mid-cycle.
REQ-018 GRANT: EBG_n[OWNER] held low while REGED[OWNER]=1; no preemption by other slots.
REQ-019 GRANT with REGED[OWNER] cleared -> RELEASE; EBG_n[OWNER] deasserted on the same edge REGED clears.
REQ-020 RELEASE: wait until FCS=0, then -> WAIT if any REGED set, else HOST; OWNER retained as last owner for round-robin.
REQ-021 Winner selection: see REQ-027; winner sampled at WAIT->GRANT transition only.
REQ-022 Slot that registers and unregisters before being granted SHALL never receive EBG_n.
REQ-023 RST=1 in any state SHALL clear REGED, deassert all EBG_n and enter HOST on the next edge; edges detected during RST are discarded.

Reset
REQ-024 RESET_n=0 SHALL, on the next CLK edge, set EBG_n all 1, HOSTGNT=1, REGED=0, OWNER=0, state HOST, synchronizer flops to 1 (idle), last-owner pointer to NSLOTS-1.
REQ-025 Reset SHALL override RST and all other inputs; no spurious edge detected on the first cycle after reset release with EBR_n held high.

Configuration
REQ-026 Macro ZORRO_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-027 Defined: winner = first registered slot scanning upward from (last owner + 1) modulo NSLOTS. Undefined: winner = lowest-indexed registered slot (fixed priority, slot 0 highest); last-owner pointer is not implemented.

Verification
REQ-028 Reset, then EBR_n[2] pulsed low 2 CLK with FCS=0 -> REGED=0b0100 at 3 CLK, EBG_n=0b1011 and OWNER=2 two CLK later, HOSTGNT=0.
REQ-029 Slot 1 granted, EBR_n[1] pulsed again with FCS=1 -> EBG_n[1]=1 when REGED[1] clears; HOST entered only after FCS=0; HOSTGNT=1.
REQ-030 Slots 0 and 3 pulse in the same cycle, FCS=0 -> both REGED set together; slot 0 granted first; after slot 0 unregisters, slot 3 granted (both policies).
REQ-031 ROUND_ROBIN_EN defined, slots 0,1 registered, slot 1 last owner -> slot 0 granted; undefined -> slot 0; with slot 0 last owner and both registered: defined -> slot 1, undefined -> slot 0.
REQ-032 RST=1 for 1 CLK while slot 2 granted -> next edge EBG_n all 1, REGED=0, HOSTGNT=1; RESET_n=0 mid-WAIT -> same values on next edge.
REQ-033 FCS=1, DTACK=0 held 10 CLK with slot 0 registered -> remains WAIT, no EBG_n asserted until FCS=0.

Source files
------------

// File: rtl/zorro_slot_arbiter.sv
// Expansion-slot bus arbiter: per-slot registration toggles, grants issued only between bus cycles.
// Define ZORRO_ARB_ROUND_ROBIN_EN for round-robin winner selection; default is fixed priority (slot 0 highest).
module zorro_slot_arbiter #(
  parameter int unsigned NSLOTS = 4
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic [NSLOTS-1:0] EBR_n,
  input  logic              FCS,
  input  logic              DTACK,
  input  logic              RST,
  output logic [NSLOTS-1:0] EBG_n,
  output logic              HOSTGNT,
  output logic [NSLOTS-1:0] REGED,
  output logic [2:0]        OWNER
);

  localparam int unsigned OW = 3;

  typedef enum logic [1:0] {
    S_HOST,
    S_WAIT,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t            state;
  logic [NSLOTS-1:0] sync1, sync2, sync_prev;
  logic [NSLOTS-1:0] fall, reged_nxt, eligible;
  logic [OW-1:0]     winner;
  logic              any_eligible;
  logic              owner_kept;
  logic              unused_dtack;

  // DTACK only qualifies cycles while FCS is high, and grants wait for FCS low anyway.
  assign unused_dtack = DTACK;

  assign fall      = sync_prev & ~sync2;
  assign reged_nxt = REGED ^ fall;
  // A slot unregistering on this very edge must never be picked.
  assign eligible  = REGED & reged_nxt;
  assign owner_kept = |(reged_nxt & ~EBG_n);

`ifdef ZORRO_ARB_ROUND_ROBIN_EN
  logic [OW-1:0] last_owner;
  int            dist, best;

  // Nearest registered slot after the last owner, wrapping around.
  always_comb begin
    winner       = '0;
    any_eligible = 1'b0;
    dist         = 0;
    best         = int'(NSLOTS);
    for (int i = 0; i < int'(NSLOTS); i++) begin
      dist = (i + int'(NSLOTS) - int'(last_owner) - 1) % int'(NSLOTS);
      if (((eligible & (NSLOTS'(1) << i)) != '0) && (dist < best)) begin
        best         = dist;
        winner       = OW'(i);
        any_eligible = 1'b1;
      end
    end
  end
`else
  // Lowest-indexed registered slot wins.
  always_comb begin
    winner       = '0;
    any_eligible = 1'b0;
    for (int i = int'(NSLOTS) - 1; i >= 0; i--) begin
      if ((eligible & (NSLOTS'(1) << i)) != '0) begin
        winner       = OW'(i);
        any_eligible = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      sync1     <= '1;
      sync2     <= '1;
      sync_prev <= '1;
      REGED     <= '0;
      EBG_n     <= '1;
      HOSTGNT   <= 1'b1;
      OWNER     <= '0;
      state     <= S_HOST;
`ifdef ZORRO_ARB_ROUND_ROBIN_EN
      last_owner <= OW'(NSLOTS - 1);
`endif
    end else begin
      sync1     <= EBR_n;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (RST) begin
        REGED   <= '0;
        EBG_n   <= '1;
        HOSTGNT <= 1'b1;
        OWNER   <= '0;
        state   <= S_HOST;
      end else begin
        REGED <= reged_nxt;
        case (state)
          S_HOST: begin
            if (|REGED) begin
              state   <= S_WAIT;
              HOSTGNT <= 1'b0;
            end
          end
          S_WAIT: begin
            if (reged_nxt == '0) begin
              state   <= S_HOST;
              HOSTGNT <= 1'b1;
              OWNER   <= '0;
            end else if (!FCS && any_eligible) begin
              state <= S_GRANT;
              EBG_n <= ~(NSLOTS'(1) << winner);
              OWNER <= winner;
`ifdef ZORRO_ARB_ROUND_ROBIN_EN
              last_owner <= winner;
`endif
            end
          end
          S_GRANT: begin
            if (!owner_kept) begin
              state <= S_RELEASE;
              EBG_n <= '1;
            end
          end
          S_RELEASE: begin
            if (!FCS) begin
              if (|REGED) begin
                state <= S_WAIT;
              end else begin
                state   <= S_HOST;
                HOSTGNT <= 1'b1;
                OWNER   <= '0;
              end
            end
          end
          default: state <= S_HOST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zorro_slot_arbiter.sv
// Bench for zorro_slot_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_zorro_slot_arbiter;

  localparam int N = 4;
  localparam int P_HOST = 0, P_WAIT = 1, P_GRANT = 2, P_RELEASE = 3;

  logic         CLK;
  logic         RESET_n, FCS, DTACK, RST;
  logic [N-1:0] EBR_n, EBG_n, REGED;
  logic         HOSTGNT;
  logic [2:0]   OWNER;

  int n_cmp = 0;
  int n_err = 0;

  // Model: pin sample history, registration set, bus phase, owner and last owner.
  logic [N-1:0] hq[$];
  logic [N-1:0] m_reg;
  int           m_phase, m_owner, m_last;

  zorro_slot_arbiter #(.NSLOTS(N)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .EBR_n(EBR_n), .FCS(FCS), .DTACK(DTACK), .RST(RST),
    .EBG_n(EBG_n), .HOSTGNT(HOSTGNT), .REGED(REGED), .OWNER(OWNER)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int pick(logic [N-1:0] cand);
`ifdef ZORRO_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int s;
      s = (m_last + k) % N;
      if (((cand >> s) & N'(1)) != '0) return s;
    end
`else
    for (int s = 0; s < N; s++)
      if (((cand >> s) & N'(1)) != '0) return s;
`endif
    return 0;
  endfunction

  task automatic model_edge();
    logic [N-1:0] tog, nreg, cand;
    if (!RESET_n) begin
      hq.delete();
      repeat (3) hq.push_front({N{1'b1}});
      m_reg = '0; m_phase = P_HOST; m_owner = 0; m_last = N - 1;
      return;
    end
    // A slot toggles when its pin was high three samples ago and low two samples ago.
    hq.push_front(EBR_n);
    tog = hq[3] & ~hq[2];
    void'(hq.pop_back());
    nreg = m_reg ^ tog;
    if (RST) begin
      m_reg = '0; m_phase = P_HOST; m_owner = 0;
      return;
    end
    case (m_phase)
      P_HOST: if (m_reg != '0) m_phase = P_WAIT;
      P_WAIT: begin
        cand = m_reg & nreg;
        if (nreg == '0) begin
          m_phase = P_HOST; m_owner = 0;
        end else if (!FCS && cand != '0) begin
          m_owner = pick(cand); m_last = m_owner; m_phase = P_GRANT;
        end
      end
      P_GRANT: if (((nreg >> m_owner) & N'(1)) == '0) m_phase = P_RELEASE;
      default: if (!FCS) begin
        if (m_reg != '0) m_phase = P_WAIT;
        else begin m_phase = P_HOST; m_owner = 0; end
      end
    endcase
    m_reg = nreg;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] e_ebg;
    @(posedge CLK);
    model_edge();
    #1;
    e_ebg = (m_phase == P_GRANT) ? ~(N'(1) << m_owner) : {N{1'b1}};
    chk("model_EBG_n",   32'(EBG_n),   32'(e_ebg));
    chk("model_HOSTGNT", 32'(HOSTGNT), 32'(m_phase == P_HOST));
    chk("model_REGED",   32'(REGED),   32'(m_reg));
    chk("model_OWNER",   32'(OWNER),   32'(m_phase == P_HOST ? 0 : m_owner));
  endtask

  // Low for two clocks, then high; the registration toggle shows on the third edge.
  task automatic pulse(logic [N-1:0] m);
    EBR_n = ~m; step(); step();
    EBR_n = '1; step();
  endtask

  task automatic do_reset();
    RESET_n = 1'b0; step(); step();
    RESET_n = 1'b1;
  endtask

  initial begin
    RESET_n = 1'b0; RST = 1'b0; FCS = 1'b0; DTACK = 1'b0; EBR_n = '1;
    do_reset();
    chk("reset_EBG_n", 32'(EBG_n), 32'hF);
    chk("reset_HOSTGNT", 32'(HOSTGNT), 32'h1);
    chk("reset_REGED", 32'(REGED), 32'h0);
    chk("reset_OWNER", 32'(OWNER), 32'h0);
    step(); step();
    chk("no_spurious_edge", 32'(REGED), 32'h0);

    // Single slot 2 request with an idle bus.
    pulse(4'b0100);
    chk("s2_reged", 32'(REGED), 32'h4);
    step();
    chk("s2_wait_hostgnt", 32'(HOSTGNT), 32'h0);
    chk("s2_wait_ebg", 32'(EBG_n), 32'hF);
    step();
    chk("s2_grant_ebg", 32'(EBG_n), 32'hB);
    chk("s2_grant_owner", 32'(OWNER), 32'h2);

    // Bus reset while slot 2 owns the bus.
    RST = 1'b1; step(); RST = 1'b0;
    chk("rst_ebg", 32'(EBG_n), 32'hF);
    chk("rst_reged", 32'(REGED), 32'h0);
    chk("rst_hostgnt", 32'(HOSTGNT), 32'h1);

    // Slot 1 unregisters mid bus cycle.
    pulse(4'b0010); step(); step();
    chk("s1_grant_ebg", 32'(EBG_n), 32'hD);
    FCS = 1'b1;
    pulse(4'b0010);
    chk("s1_release_ebg", 32'(EBG_n), 32'hF);
    chk("s1_release_reged", 32'(REGED), 32'h0);
    repeat (3) step();
    chk("s1_hold_hostgnt", 32'(HOSTGNT), 32'h0);
    FCS = 1'b0; step();
    chk("s1_host_hostgnt", 32'(HOSTGNT), 32'h1);

    // Policy check: slots 0,1 registered with slot 1, then slot 0, as last owner.
    pulse(4'b0010); step(); step();
    FCS = 1'b1;
    pulse(4'b0011);
    pulse(4'b0010);
    FCS = 1'b0; step(); step();
    chk("pol_last1_ebg", 32'(EBG_n), 32'hE);
    FCS = 1'b1;
    pulse(4'b0001);
    pulse(4'b0001);
    FCS = 1'b0; step(); step();
`ifdef ZORRO_ARB_ROUND_ROBIN_EN
    chk("pol_last0_ebg", 32'(EBG_n), 32'hD);
`else
    chk("pol_last0_ebg", 32'(EBG_n), 32'hE);
`endif
    pulse(4'b0011); step();

    // Slots 0 and 3 register together.
    do_reset();
    pulse(4'b1001);
    chk("s03_reged", 32'(REGED), 32'h9);
    step(); step();
    chk("s03_first_ebg", 32'(EBG_n), 32'hE);
    chk("s03_first_owner", 32'(OWNER), 32'h0);
    pulse(4'b0001);
    chk("s03_release_ebg", 32'(EBG_n), 32'hF);
    step(); step();
    chk("s03_second_ebg", 32'(EBG_n), 32'h7);
    chk("s03_second_owner", 32'(OWNER), 32'h3);
    pulse(4'b1000); step();

    // Long unacknowledged bus cycle blocks the grant.
    FCS = 1'b1; DTACK = 1'b0;
    pulse(4'b0001);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("longcyc_ebg", 32'(EBG_n), 32'hF);
    end
    FCS = 1'b0; step();
    chk("longcyc_grant_ebg", 32'(EBG_n), 32'hE);
    pulse(4'b0001); step();

    // Chip reset while waiting.
    FCS = 1'b1;
    pulse(4'b0010); step();
    chk("midwait_hostgnt", 32'(HOSTGNT), 32'h0);
    RESET_n = 1'b0; step(); RESET_n = 1'b1;
    chk("midwait_rst_ebg", 32'(EBG_n), 32'hF);
    chk("midwait_rst_reged", 32'(REGED), 32'h0);
    chk("midwait_rst_hostgnt", 32'(HOSTGNT), 32'h1);
    chk("midwait_rst_owner", 32'(OWNER), 32'h0);
    FCS = 1'b0;

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(5) == 0) EBR_n = EBR_n ^ (N'(1) << $urandom_range(N - 1));
      FCS     = 1'($urandom_range(1));
      DTACK   = 1'($urandom_range(1));
      RST     = ($urandom_range(63) == 0);
      RESET_n = ($urandom_range(127) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
